// File: rtl/adder_sum_accumulator.sv
// Accumulates COUNT_N 5-bit operands ({in_cout, in_sum}) from an upstream 4-bit adder
// into an ACC_W-bit block total, then presents the total until the consumer takes it.
// Optional build macro: ADDER_SUM_ACCUMULATOR_SATURATE_EN clamps the accumulator at its
// maximum on overflow; without it the accumulator wraps. The sticky overflow flag is set
// in both builds.
module adder_sum_accumulator #(
  parameter int unsigned ACC_W   = 8,
  parameter int unsigned COUNT_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_sum,
  input  logic             in_cout,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] out_total,
  output logic [7:0]       out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int unsigned SumW      = ACC_W + 1;
  localparam logic [7:0]  CountLast = 8'(COUNT_N);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_d;
  logic [7:0]       r_count;
  logic [7:0]       w_count_d;
  logic             r_ovf;
  logic             w_ovf_d;
  logic             r_in_ready;
  logic             w_in_ready_d;
  logic             r_out_valid;
  logic             w_out_valid_d;

  logic             w_xfer;
  logic [7:0]       w_count_inc;
  logic [SumW-1:0]  w_sum;
  logic [ACC_W-1:0] w_operand;

  assign w_xfer      = in_valid & r_in_ready;
  assign w_count_inc = r_count + 8'd1;
  assign w_operand   = ACC_W'({in_cout, in_sum});
  // Extra top bit catches the carry out of the ACC_W-bit accumulator.
  assign w_sum       = {1'b0, r_acc} + SumW'({in_cout, in_sum});

  // State register plus registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_in_ready  <= w_in_ready_d;
      r_out_valid <= w_out_valid_d;
    end
  end

  // Next-state logic; clear overrides every transfer and handshake.
  always_comb begin
    w_state_d = r_state;
    if (clear) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_xfer) w_state_d = (COUNT_N == 1) ? StHold : StAccum;
        end
        StAccum: begin
          if (w_xfer && (w_count_inc == CountLast)) w_state_d = StHold;
        end
        StHold: begin
          if (out_ready) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Output decode from the next state so both handshake outputs come straight from flops.
  always_comb begin
    w_in_ready_d  = (w_state_d != StHold);
    w_out_valid_d = (w_state_d == StHold);
  end

  // Datapath next-state: accumulator, operand count and sticky overflow.
  always_comb begin
    w_acc_d   = r_acc;
    w_count_d = r_count;
    w_ovf_d   = r_ovf;
    if (clear) begin
      w_acc_d   = '0;
      w_count_d = '0;
      w_ovf_d   = 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_xfer) begin
            // A single 5-bit operand always fits since ACC_W >= 5.
            w_acc_d   = w_operand;
            w_count_d = 8'd1;
            w_ovf_d   = 1'b0;
          end
        end
        StAccum: begin
          if (w_xfer) begin
            w_count_d = w_count_inc;
            w_ovf_d   = r_ovf | w_sum[ACC_W];
`ifdef ADDER_SUM_ACCUMULATOR_SATURATE_EN
            w_acc_d   = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
            w_acc_d   = w_sum[ACC_W-1:0];
`endif
          end
        end
        StHold: begin
          if (out_ready) begin
            w_acc_d   = '0;
            w_count_d = '0;
            w_ovf_d   = 1'b0;
          end
        end
        default: begin
          w_acc_d   = '0;
          w_count_d = '0;
          w_ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_acc   <= w_acc_d;
      r_count <= w_count_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_total = r_acc;
  assign out_count = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: a default-width DUT and an ACC_W=6 DUT share stimulus.
// A block-level model (true running total, operand count, holding flag) predicts both.
module tb_adder_sum_accumulator;

  localparam int CountN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_sum;
  logic       in_cout;
  logic       in_valid;
  logic       clear;
  logic       out_ready;

  logic       in_ready, out_valid, overflow;
  logic [7:0] out_total, out_count;
  logic       in_ready6, out_valid6, overflow6;
  logic [5:0] out_total6;
  logic [7:0] out_count6;

  adder_sum_accumulator #(.ACC_W(8), .COUNT_N(CountN)) dut (
    .clk(clk), .rst_n(rst_n), .in_sum(in_sum), .in_cout(in_cout), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .out_total(out_total), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );

  adder_sum_accumulator #(.ACC_W(6), .COUNT_N(CountN)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_sum(in_sum), .in_cout(in_cout), .in_valid(in_valid),
    .in_ready(in_ready6), .clear(clear), .out_total(out_total6), .out_count(out_count6),
    .out_valid(out_valid6), .out_ready(out_ready), .overflow(overflow6)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int m_sum;
  int m_cnt;
  bit m_hold;
  bit m_rdy;

  typedef struct {
    bit v;
    bit clr;
    bit ordy;
    int op;
    int e_tot;
    int e_cnt;
    bit e_val;
    bit e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_total(input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef ADDER_SUM_ACCUMULATOR_SATURATE_EN
    return (m_sum > mx) ? mx : m_sum;
`else
    return m_sum % (mx + 1);
`endif
  endfunction

  task automatic model_reset();
    m_sum  = 0;
    m_cnt  = 0;
    m_hold = 0;
    m_rdy  = 0;
  endtask

  // Effect of the coming clock edge on a block, given the inputs now on the pins.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (clear) begin
        m_sum = 0; m_cnt = 0; m_hold = 0;
      end else if (m_hold) begin
        if (out_ready) begin
          m_sum = 0; m_cnt = 0; m_hold = 0;
        end
      end else if (in_valid && m_rdy) begin
        m_sum += int'({in_cout, in_sum});
        m_cnt++;
        if (m_cnt == CountN) m_hold = 1;
      end
      m_rdy = !m_hold;
    end
  endtask

  task automatic check_all();
    chk("in_ready", int'(in_ready), int'(m_rdy));
    chk("out_valid", int'(out_valid), int'(m_hold));
    chk("out_count", int'(out_count), m_cnt);
    chk("out_total", int'(out_total), exp_total(8));
    chk("overflow", int'(overflow), int'(m_sum > 255));
    chk("in_ready6", int'(in_ready6), int'(m_rdy));
    chk("out_valid6", int'(out_valid6), int'(m_hold));
    chk("out_count6", int'(out_count6), m_cnt);
    chk("out_total6", int'(out_total6), exp_total(6));
    chk("overflow6", int'(overflow6), int'(m_sum > 63));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit clr, input bit ordy, input int op);
    in_valid  = v;
    clear     = clr;
    out_ready = ordy;
    {in_cout, in_sum} = 5'(op);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_total"}, int'(out_total), 0);
    chk({tag, "_out_count"}, int'(out_count), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_out_total6"}, int'(out_total6), 0);
    chk({tag, "_overflow6"}, int'(overflow6), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    #1;
    chk_zero_outputs("reset");
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", int'(in_ready), 0);
    step();
    chk("ready_after_release", int'(in_ready), 1);

    // Directed block sequences: basic block, HOLD stall, handshake, clear mid-block.
    tbl.push_back('{1, 0, 0, 4,  4,  1, 0, 1});
    tbl.push_back('{1, 0, 0, 9,  13, 2, 0, 1});
    tbl.push_back('{1, 0, 0, 10, 23, 3, 0, 1});
    tbl.push_back('{1, 0, 0, 16, 39, 4, 1, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1, 0, 0, 5, 39, 4, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 0,  0, 0, 1});
    tbl.push_back('{1, 0, 0, 4,  4,  1, 0, 1});
    tbl.push_back('{1, 0, 0, 9,  13, 2, 0, 1});
    tbl.push_back('{1, 1, 0, 10, 0,  0, 0, 1});
    tbl.push_back('{1, 0, 0, 1,  1,  1, 0, 1});
    tbl.push_back('{1, 0, 0, 2,  3,  2, 0, 1});
    tbl.push_back('{1, 0, 0, 3,  6,  3, 0, 1});
    tbl.push_back('{1, 0, 0, 4,  10, 4, 1, 0});
    tbl.push_back('{1, 0, 1, 7,  0,  0, 0, 1});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].clr, tbl[i].ordy, tbl[i].op);
      step();
      chk($sformatf("tbl%0d_total", i), int'(out_total), tbl[i].e_tot);
      chk($sformatf("tbl%0d_count", i), int'(out_count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].e_val));
      chk($sformatf("tbl%0d_ready", i), int'(in_ready), int'(tbl[i].e_rdy));
    end

    // Reset in the middle of a block discards it.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 6);
      step();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero_outputs("midreset");
    drive(1, 0, 1, 6);
    repeat (2) begin
      step();
      chk("midreset_no_valid", int'(out_valid), 0);
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1);
      step();
    end
    chk("after_reset_total", int'(out_total), 4);
    chk("after_reset_valid", int'(out_valid), 1);
    drive(0, 0, 1, 0);
    step();

    // Four maximum operands overflow the 6-bit total.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 31);
      step();
    end
`ifdef ADDER_SUM_ACCUMULATOR_SATURATE_EN
    chk("w6_total", int'(out_total6), 63);
`else
    chk("w6_total", int'(out_total6), 60);
`endif
    chk("w6_overflow", int'(overflow6), 1);
    chk("w8_total", int'(out_total), 124);
    chk("w8_overflow", int'(overflow), 0);
    drive(0, 0, 1, 0);
    step();
    chk("w6_ovf_cleared", int'(overflow6), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 31)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_sum_accumulator.md
ADDER_SUM_ACCUMULATOR -- requirements
Module: adder_sum_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 8, accumulator/total width in bits (legal 5..16).
REQ-002 SHALL have parameter COUNT_N, default 4, number of adder results summed per block (legal 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_sum  input  4  sum output of the upstream 4-bit parallel adder.
REQ-006 SHALL have port in_cout  input  1  carry output of the upstream adder; the operand value is {in_cout,in_sum}, range 0..31.
REQ-007 SHALL have port in_valid  input  1  operand present.
REQ-008 SHALL have port in_ready  output  1  block can accept; a transfer occurs when in_valid and in_ready are high on the same edge.
REQ-009 SHALL have port clear  input  1  synchronous abort of the current block.
REQ-010 SHALL have port out_total  output  ACC_W  accumulated block total.
REQ-011 SHALL have port out_count  output  8  number of operands accepted in the current block.
REQ-012 SHALL have port out_valid  output  1  block total available.
REQ-013 SHALL have port out_ready  input  1  consumer takes the total when out_valid and out_ready are high on the same edge.
REQ-014 SHALL have port overflow  output  1  sticky flag: the block total exceeded 2^ACC_W-1.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-016 IDLE: in_ready=1, accumulator=0, count=0; a transfer loads the accumulator with the operand and sets count=1; next state is HOLD if COUNT_N=1, else ACCUM.
REQ-017 ACCUM: in_ready=1; each transfer adds the operand zero-extended to ACC_W+1 bits and increments count; when count reaches COUNT_N the next state is HOLD.
REQ-018 Cycles without a transfer SHALL leave the accumulator, count and state unchanged.
REQ-019 HOLD: in_ready=0, out_valid=1; out_total, out_count and overflow SHALL stay stable until the out_ready handshake.
REQ-020 A HOLD handshake SHALL return the FSM to IDLE and clear the accumulator, count and overflow on that edge.
REQ-021 Latency: out_valid SHALL rise on the edge after the COUNT_N-th transfer edge; out_valid is registered.
REQ-022 out_total SHALL always show the live accumulator and out_count the live count; out_valid is 0 outside HOLD.
REQ-023 Overflow: when the ACC_W+1-bit sum has bit ACC_W set, overflow SHALL be set and stay set until the block is delivered or cleared.
REQ-024 clear SHALL take priority over every transfer and handshake in the same cycle: next state is IDLE, and the accumulator, count and overflow become 0; the input transfer in that cycle is discarded.
REQ-025 in_ready SHALL depend only on registered state, with no combinational path from in_valid or out_ready.

Reset
REQ-026 While rst_n=0 the block SHALL hold state IDLE, out_total=0, out_count=0, out_valid=0, overflow=0, in_ready=0; in_ready is 1 from the first edge after release.
REQ-027 Reset asserted mid-block or in HOLD SHALL discard the partial or pending total with no output handshake.

Configuration
REQ-028 Macro ADDER_SUM_ACCUMULATOR_SATURATE_EN: when defined, an overflowing addition SHALL clamp the accumulator to 2^ACC_W-1, and later additions keep it there.
REQ-029 Without ADDER_SUM_ACCUMULATOR_SATURATE_EN the accumulator SHALL wrap modulo 2^ACC_W; overflow behaves as in REQ-023 in both builds.

Verification
REQ-030 Defaults; transfer operands 3+1, 5+4, 7+3, 15+1 (in_cout=1, in_sum=0) on consecutive cycles -> out_valid on the next edge, out_total=39, out_count=4, overflow=0.
REQ-031 ACC_W=6; four transfers of 31 -> wrap build: out_total=60, overflow=1; SATURATE_EN build: out_total=63, overflow=1.
REQ-032 In HOLD, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_total stable at 39; out_ready=1 -> IDLE next edge, out_total=0.
REQ-033 Two transfers (4, 9), then clear together with in_valid=1 operand 10 -> IDLE, out_total=0, out_count=0; the next four operands produce a fresh correct total.
REQ-034 rst_n pulsed low after 3 transfers -> all outputs 0 during reset, no out_valid; a subsequent block of four operands of 1 gives out_total=4.
